// File: rtl/lsm_decision_poly.sv
// Longstaff-Schwartz exercise decision for one backward-induction step:
// Horner evaluation of the continuation polynomial, then exercise-vs-hold choice.
module lsm_decision_poly #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned QFRAC   = 16,
    parameter int unsigned DEGREE  = 2,
    parameter bit          IS_CALL = 1'b0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic signed [WIDTH-1:0]        S_t,
    input  logic [DEGREE:0][WIDTH-1:0]     beta,
    input  logic signed [WIDTH-1:0]        strike,
    input  logic signed [WIDTH-1:0]        disc,
    input  logic signed [WIDTH-1:0]        cf_next,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic signed [WIDTH-1:0]        PV,
    output logic                           exercise,
    output logic signed [WIDTH-1:0]        cont,
    input  logic                           cnt_clr,
    output logic [CNT_W-1:0]               ex_count
);

    localparam int unsigned K_W = $clog2(DEGREE + 1);
    localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, EVAL, DECIDE, OUT} state_e;

    // Clamp a one-bit-wider sum/difference back into the word range.
    function automatic logic signed [WIDTH-1:0] sat_narrow(input logic signed [WIDTH:0] v);
        if (v[WIDTH] != v[WIDTH-1]) begin
            return v[WIDTH] ? S_MIN : S_MAX;
        end
        return v[WIDTH-1:0];
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_add(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
        return sat_narrow((WIDTH+1)'(a) + (WIDTH+1)'(b));
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
        return sat_narrow((WIDTH+1)'(a) - (WIDTH+1)'(b));
    endfunction

    // Full-width product, floor shift by QFRAC, saturate.
    function automatic logic signed [WIDTH-1:0] fx_mul(input logic signed [WIDTH-1:0] a,
                                                       input logic signed [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        p = p >>> QFRAC;
        if ((&p[2*WIDTH-1:WIDTH-1]) || !(|p[2*WIDTH-1:WIDTH-1])) begin
            return p[WIDTH-1:0];
        end
        return p[2*WIDTH-1] ? S_MIN : S_MAX;
    endfunction

    state_e                     state_q, state_d;
    logic signed [WIDTH-1:0]    s_q, s_d, strike_q, strike_d, disc_q, disc_d, cf_q, cf_d;
    logic [DEGREE:0][WIDTH-1:0] beta_q, beta_d;
    logic signed [WIDTH-1:0]    acc_q, acc_d;
    logic [K_W-1:0]             k_q, k_d;
    logic signed [WIDTH-1:0]    pv_q, pv_d, cont_q, cont_d;
    logic                       ex_q, ex_d, ov_q, ov_d, ir_q, ir_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    logic signed [WIDTH-1:0]    diff_c, payoff_c, hold_c;
    logic                       exer_c;

    // Decision datapath, consumed only in DECIDE.
    always_comb begin
        diff_c   = IS_CALL ? sat_sub(s_q, strike_q) : sat_sub(strike_q, s_q);
        payoff_c = diff_c[WIDTH-1] ? '0 : diff_c;
        hold_c   = fx_mul(disc_q, cf_q);
        exer_c   = (payoff_c != '0) && (payoff_c >= acc_q);
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        strike_d = strike_q;
        disc_d   = disc_q;
        cf_d     = cf_q;
        beta_d   = beta_q;
        acc_d    = acc_q;
        k_d      = k_q;
        pv_d     = pv_q;
        cont_d   = cont_q;
        ex_d     = ex_q;
        ov_d     = ov_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && ir_q) begin
                    s_d      = S_t;
                    strike_d = strike;
                    disc_d   = disc;
                    cf_d     = cf_next;
                    beta_d   = beta;
                    acc_d    = $signed(beta[DEGREE]);
                    k_d      = K_W'(DEGREE - 1);
                    state_d  = EVAL;
                end
            end
            EVAL: begin
                acc_d = sat_add(fx_mul(acc_q, s_q), $signed(beta_q[k_q]));
                if (k_q == '0) begin
                    state_d = DECIDE;
                end else begin
                    k_d = k_q - K_W'(1);
                end
            end
            DECIDE: begin
                pv_d    = exer_c ? payoff_c : hold_c;
                ex_d    = exer_c;
                cont_d  = acc_q;
                ov_d    = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        ir_d = (state_d == IDLE);

        // Clear wins over a simultaneous exercise; count saturates.
        if (cnt_clr) begin
            cnt_d = '0;
        end else if ((state_q == DECIDE) && exer_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            s_q      <= '0;
            strike_q <= '0;
            disc_q   <= '0;
            cf_q     <= '0;
            beta_q   <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            pv_q     <= '0;
            cont_q   <= '0;
            ex_q     <= 1'b0;
            ov_q     <= 1'b0;
            ir_q     <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            strike_q <= strike_d;
            disc_q   <= disc_d;
            cf_q     <= cf_d;
            beta_q   <= beta_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            pv_q     <= pv_d;
            cont_q   <= cont_d;
            ex_q     <= ex_d;
            ov_q     <= ov_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = ir_q;
    assign out_valid = ov_q;
    assign PV        = pv_q;
    assign exercise  = ex_q;
    assign cont      = cont_q;
    assign ex_count  = cnt_q;

endmodule

// File: tb/tb_lsm_decision_poly.sv
// Randomised + directed bench for lsm_decision_poly (put and call instances in lockstep)
// against a plain-arithmetic reference model.
module tb_lsm_decision_poly;

    logic clk, rst_n, in_valid, out_ready, cnt_clr;
    logic signed [31:0] S_t, strike, disc, cf_next;
    logic [2:0][31:0] beta;

    logic in_ready, out_valid, exercise;
    logic signed [31:0] PV, cont;
    logic [15:0] ex_count;

    logic c_in_ready, c_out_valid, c_exercise;
    logic signed [31:0] c_PV, c_cont;
    logic [15:0] c_ex_count;

    lsm_decision_poly dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .S_t(S_t), .beta(beta), .strike(strike), .disc(disc), .cf_next(cf_next),
        .out_valid(out_valid), .out_ready(out_ready), .PV(PV), .exercise(exercise),
        .cont(cont), .cnt_clr(cnt_clr), .ex_count(ex_count)
    );

    lsm_decision_poly #(.IS_CALL(1'b1)) dut_call (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
        .S_t(S_t), .beta(beta), .strike(strike), .disc(disc), .cf_next(cf_next),
        .out_valid(c_out_valid), .out_ready(out_ready), .PV(c_PV), .exercise(c_exercise),
        .cont(c_cont), .cnt_clr(cnt_clr), .ex_count(c_ex_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_total = 0;
    int n_bad   = 0;
    int cnt_put = 0;
    int cnt_cl  = 0;

    localparam longint LMAX = 2147483647;
    localparam longint LMIN = -LMAX - 1;

    typedef struct {
        longint cont;
        longint pv;
        bit     ex;
    } res_t;

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint clamp(input longint v);
        if (v > LMAX) return LMAX;
        if (v < LMIN) return LMIN;
        return v;
    endfunction

    function automatic longint qmul(input longint a, input longint b);
        return clamp((a * b) >>> 16);
    endfunction

    function automatic res_t model(input longint s, input longint k, input longint b0,
                                   input longint b1, input longint b2, input longint d,
                                   input longint cf, input bit call);
        res_t   r;
        longint bt[3];
        longint acc, payoff, hold;
        bt[0] = b0; bt[1] = b1; bt[2] = b2;
        acc = bt[2];
        for (int i = 1; i >= 0; i--) acc = clamp(qmul(acc, s) + bt[i]);
        payoff = call ? clamp(s - k) : clamp(k - s);
        if (payoff < 0) payoff = 0;
        hold   = qmul(d, cf);
        r.cont = acc;
        r.ex   = (payoff > 0) && (payoff >= acc);
        r.pv   = r.ex ? payoff : hold;
        return r;
    endfunction

    task automatic run_path(input logic signed [31:0] s, input logic signed [31:0] k,
                            input logic signed [31:0] b0, input logic signed [31:0] b1,
                            input logic signed [31:0] b2, input logic signed [31:0] d,
                            input logic signed [31:0] cf, input int stall, input bit clr,
                            output logic signed [31:0] pv_o, output logic ex_o,
                            output logic signed [31:0] cont_o, output logic signed [31:0] cpv_o,
                            output logic cex_o);
        res_t ep, ec;
        int   waitc, lat;
        ep = model(s, k, b0, b1, b2, d, cf, 1'b0);
        ec = model(s, k, b0, b1, b2, d, cf, 1'b1);

        @(negedge clk);
        S_t = s; strike = k; disc = d; cf_next = cf;
        beta[0] = b0; beta[1] = b1; beta[2] = b2;
        in_valid = 1'b1;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check_eq("in_ready_wait", in_ready, 1);
        @(posedge clk);
        #1;
        // Upstream may present anything now; it must be ignored outside IDLE.
        in_valid = 1'($urandom_range(0, 1));
        S_t = $urandom; strike = $urandom; disc = $urandom; cf_next = $urandom;
        beta = {$urandom, $urandom, $urandom};

        lat = 0;
        while (!out_valid && lat < 20) begin
            if (clr && lat == 2) cnt_clr = 1'b1;
            @(posedge clk);
            #1;
            cnt_clr = 1'b0;
            lat++;
        end
        check_eq("latency", lat, 3);

        if (clr) begin
            cnt_put = 0;
            cnt_cl  = 0;
        end else begin
            if (ep.ex && cnt_put < 65535) cnt_put++;
            if (ec.ex && cnt_cl < 65535) cnt_cl++;
        end

        check_eq("cont", cont, ep.cont);
        check_eq("exercise", exercise, ep.ex);
        check_eq("pv", PV, ep.pv);
        check_eq("ex_count", ex_count, cnt_put);
        check_eq("in_ready_busy", in_ready, 0);
        check_eq("call_valid", c_out_valid, 1);
        check_eq("call_cont", c_cont, ec.cont);
        check_eq("call_exercise", c_exercise, ec.ex);
        check_eq("call_pv", c_PV, ec.pv);
        check_eq("call_ex_count", c_ex_count, cnt_cl);
        pv_o = PV; ex_o = exercise; cont_o = cont; cpv_o = c_PV; cex_o = c_exercise;

        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_pv", PV, ep.pv);
            check_eq("stall_exercise", exercise, ep.ex);
            check_eq("stall_in_ready", in_ready, 0);
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("valid_drop", out_valid, 0);
        check_eq("in_ready_back", in_ready, 1);
    endtask

    logic signed [31:0] r_pv, r_cont, r_cpv, rs, rk, rb0, rb1, rb2, rd, rcf;
    logic               r_ex, r_cex;
    bit                 ov_seen;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
        S_t = '0; strike = '0; disc = '0; cf_next = '0; beta = '0;
        #1;
        check_eq("rst_in_ready", in_ready, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_pv", PV, 0);
        check_eq("rst_cont", cont, 0);
        check_eq("rst_ex_count", ex_count, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        check_eq("rel_in_ready_high", in_ready, 1);

        // Hold, with 5 cycles of backpressure
        run_path(32'h00010000, 32'h00011999, 32'h8000, 0, 0, 32'h8000, 32'h3333, 5, 1'b0,
                 r_pv, r_ex, r_cont, r_cpv, r_cex);
        check_eq("hold_cont", r_cont, 32'h8000);
        check_eq("hold_ex", r_ex, 0);
        check_eq("hold_pv", r_pv, 32'h1999);

        // Exercise
        run_path(32'h00010000, 32'h00011999, 32'h0CCC, 0, 0, 32'h8000, 32'h3333, 0, 1'b0,
                 r_pv, r_ex, r_cont, r_cpv, r_cex);
        check_eq("exer_ex", r_ex, 1);
        check_eq("exer_pv", r_pv, 32'h1999);
        check_eq("exer_count", ex_count, 1);

        // Out of the money with a negative continuation value
        run_path(32'h00013333, 32'h00011999, 32'hFFFF0000, 0, 0, 32'h8000, 32'h3333, 1, 1'b0,
                 r_pv, r_ex, r_cont, r_cpv, r_cex);
        check_eq("otm_ex", r_ex, 0);
        check_eq("otm_pv", r_pv, 32'h1999);

        // Horner evaluation: 1 + 2*S + 3*S^2 at S=2
        run_path(32'h00020000, 32'h00011999, 32'h10000, 32'h20000, 32'h30000, 32'h8000, 32'h3333,
                 0, 1'b0, r_pv, r_ex, r_cont, r_cpv, r_cex);
        check_eq("horner_cont", r_cont, 32'h00110000);

        // Positive saturation inside Horner
        run_path(32'h00020000, 32'h00011999, 0, 0, 32'h7FFF0000, 32'h8000, 32'h3333,
                 2, 1'b0, r_pv, r_ex, r_cont, r_cpv, r_cex);
        check_eq("sat_cont", r_cont, 32'h7FFFFFFF);

        // Call payoff on the IS_CALL instance
        run_path(32'h00013333, 32'h00010000, 0, 0, 0, 32'h8000, 32'h3333, 0, 1'b0,
                 r_pv, r_ex, r_cont, r_cpv, r_cex);
        check_eq("call_mode_ex", r_cex, 1);
        check_eq("call_mode_pv", r_cpv, 32'h3333);

        // Reset in the middle of EVAL discards the path
        @(negedge clk);
        S_t = 32'h00010000; strike = 32'h00011999; disc = 32'h8000; cf_next = 32'h3333;
        beta = '0;
        beta[0] = 32'h0CCC;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        cnt_put = 0;
        cnt_cl  = 0;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_pv", PV, 0);
        check_eq("mid_rst_exercise", exercise, 0);
        check_eq("mid_rst_cont", cont, 0);
        check_eq("mid_rst_ex_count", ex_count, 0);
        check_eq("mid_rst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ov_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) ov_seen = 1'b1;
        end
        check_eq("aborted_no_output", ov_seen, 0);
        check_eq("post_rst_in_ready", in_ready, 1);

        // Three exercising paths, clear coinciding with the third decision
        for (int i = 0; i < 3; i++) begin
            run_path(32'h00010000, 32'h00011999, 32'h0CCC, 0, 0, 32'h8000, 32'h3333, 0, (i == 2),
                     r_pv, r_ex, r_cont, r_cpv, r_cex);
        end
        check_eq("clr_priority", ex_count, 0);

        // Random paths
        for (int n = 0; n < 40; n++) begin
            rs  = 32'($urandom_range(32'h8000, 32'h18000));
            rk  = 32'h10000 + 32'($urandom_range(0, 32'h4000));
            rb0 = 32'($urandom_range(0, 32'h20000)) - 32'h10000;
            rb1 = 32'($urandom_range(0, 32'h20000)) - 32'h10000;
            rb2 = 32'($urandom_range(0, 32'h20000)) - 32'h10000;
            if (n % 8 == 7) begin
                rb2 = $urandom;
                rb1 = $urandom;
            end
            rd  = 32'($urandom_range(32'hF000, 32'h10000));
            rcf = 32'($urandom_range(0, 32'h8000));
            run_path(rs, rk, rb0, rb1, rb2, rd, rcf, int'($urandom_range(0, 3)), 1'b0,
                     r_pv, r_ex, r_cont, r_cpv, r_cex);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
